// File: rtl/gmii_tx_arbiter.sv
// Round-robin sharing of one GMII transmit path between two byte-stream sources, with preamble/SFD,
// inter-frame gap, underrun and oversize handling. Define FCS_APPEND_EN to append a CRC-32 FCS.
module gmii_tx_arbiter #(
  parameter int PREAMBLE_LEN    = 7,
  parameter int IFG_CYCLES      = 12,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic       gmii_tx_clk,
  input  logic       reset_n,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       gmii_txer,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [10:0] MAX_B    = 11'(MAX_FRAME_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_DATA, ST_ERR, ST_DRAIN, ST_IFG, ST_FCS
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [10:0] byte_cnt;
  logic        pref;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

`ifdef FCS_APPEND_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  assign sel_valid = grant[1] ? s1_valid : (grant[0] & s0_valid);
  assign sel_last  = grant[1] ? s1_last  : s0_last;
  assign sel_data  = grant[1] ? s1_data  : s0_data;

  // Ready is withheld during the underrun error cycle (ST_ERR) and everywhere outside DATA/DRAIN.
  assign s0_ready = ((state == ST_DATA) || (state == ST_DRAIN)) && grant[0];
  assign s1_ready = ((state == ST_DATA) || (state == ST_DRAIN)) && grant[1];
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge gmii_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      byte_cnt  <= '0;
      pref      <= 1'b0;
      grant     <= 2'b00;
      gmii_txd  <= '0;
      gmii_txen <= 1'b0;
      gmii_txer <= 1'b0;
`ifdef FCS_APPEND_EN
      crc       <= 32'hFFFFFFFF;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          gmii_txd  <= '0;
          gmii_txen <= 1'b0;
          gmii_txer <= 1'b0;
          if (s0_valid || s1_valid) begin
            state     <= ST_PRE;
            gmii_txen <= 1'b1;
            gmii_txd  <= 8'h55;
            cnt       <= 8'd1;
            byte_cnt  <= '0;
            // pref==0 means source 0 wins a tie; the loser of this decision is preferred next.
            if (s0_valid && (!s1_valid || !pref)) begin
              grant <= 2'b01;
              pref  <= 1'b1;
            end else begin
              grant <= 2'b10;
              pref  <= 1'b0;
            end
          end
        end
        ST_PRE: begin
          gmii_txen <= 1'b1;
          gmii_txer <= 1'b0;
          if (cnt >= PRE_LAST) begin
            gmii_txd <= 8'hD5;
            state    <= ST_DATA;
`ifdef FCS_APPEND_EN
            crc      <= 32'hFFFFFFFF;
`endif
          end else begin
            gmii_txd <= 8'h55;
            cnt      <= cnt + 8'd1;
          end
        end
        ST_DATA: begin
          gmii_txen <= 1'b1;
          if (sel_valid) begin
            gmii_txd  <= sel_data;
            gmii_txer <= 1'b0;
            byte_cnt  <= sat_inc(byte_cnt);
`ifdef FCS_APPEND_EN
            crc       <= crc_byte(crc, sel_data);
`endif
            if (sel_last) begin
              cnt   <= '0;
`ifdef FCS_APPEND_EN
              state <= ST_FCS;
`else
              state <= ST_IFG;
`endif
            end else if (byte_cnt >= MAX_B) begin
              gmii_txer <= 1'b1;
              state     <= ST_DRAIN;
            end
          end else begin
            gmii_txd  <= '0;
            gmii_txer <= 1'b1;
            state     <= ST_ERR;
          end
        end
        ST_ERR: begin
          gmii_txd  <= '0;
          gmii_txen <= 1'b0;
          gmii_txer <= 1'b0;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          gmii_txd  <= '0;
          gmii_txen <= 1'b0;
          gmii_txer <= 1'b0;
          if (sel_valid && sel_last) begin
            state <= ST_IFG;
            cnt   <= '0;
          end
        end
        ST_IFG: begin
          gmii_txd  <= '0;
          gmii_txen <= 1'b0;
          gmii_txer <= 1'b0;
          if (cnt >= IFG_LAST) begin
            state <= ST_IDLE;
            grant <= 2'b00;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`ifdef FCS_APPEND_EN
        ST_FCS: begin
          gmii_txen <= 1'b1;
          gmii_txer <= 1'b0;
          gmii_txd  <= ~crc[7:0];
          crc       <= {8'h00, crc[31:8]};
          if (cnt == 8'd3) begin
            state <= ST_IFG;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          grant     <= 2'b00;
          gmii_txd  <= '0;
          gmii_txen <= 1'b0;
          gmii_txer <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter (default build): table of frame scenarios plus
// hand-written reset-mid-frame and back-to-back sequences.
module tb_gmii_tx_arbiter;

  localparam int MAX_B = 1518;
  localparam int IFG   = 12;

  logic       clk;
  logic       reset_n;
  logic       s0_valid, s0_last, s0_ready;
  logic [7:0] s0_data;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] s1_data;
  logic [7:0] gmii_txd;
  logic       gmii_txen, gmii_txer;
  logic [1:0] grant;
  logic       busy;

  gmii_tx_arbiter #(.PREAMBLE_LEN(7), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAX_B)) dut (
    .gmii_tx_clk(clk), .reset_n(reset_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .gmii_txd(gmii_txd), .gmii_txen(gmii_txen), .gmii_txer(gmii_txer),
    .grant(grant), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int         mask;       // 1: s0, 2: s1, 3: both
    int         first;      // source expected to be served first
    int         len0;
    int         len1;
    int         gap0;       // s0 drops valid once after this many bytes (-1: never)
    bit         over1;      // s1 is the oversize stream
    int         exp_frames;
    logic [1:0] exp_grant;
    int         exp_txen;
    int         exp_txer;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // monitor state
  logic [8:0] bytes_q[$];
  int         flen_q[$];
  logic [1:0] fgrant_q[$];
  int         gap_q[$];
  logic [8:0] exp_q[$];

  initial begin
    bit in_frame;
    int run_len;
    int low_run;
    in_frame = 0; run_len = 0; low_run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        if (in_frame) flen_q.push_back(run_len);
        in_frame = 0; run_len = 0; low_run = 0;
      end else if (gmii_txen) begin
        if (!in_frame) begin
          fgrant_q.push_back(grant);
          gap_q.push_back(low_run);
          in_frame = 1; run_len = 0;
        end
        bytes_q.push_back({gmii_txer, gmii_txd});
        run_len++;
      end else begin
        if (in_frame) begin
          flen_q.push_back(run_len);
          in_frame = 0; low_run = 0;
        end
        low_run++;
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_src(input int src, input logic v, input logic [7:0] d, input logic l);
    if (src == 0) begin s0_valid = v; s0_data = d; s0_last = l; end
    else          begin s1_valid = v; s1_data = d; s1_last = l; end
  endtask

  task automatic drive(input int src, input int len, input int gap_at,
                       input logic [7:0] base, output int sent);
    int  i;
    int  budget;
    bit  acc;
    bit  gapped;
    i = 0; budget = 6000; gapped = 0;
    while (i < len && budget > 0) begin
      budget--;
      if (i == gap_at && !gapped) begin
        gapped = 1;
        set_src(src, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
      end else begin
        set_src(src, 1'b1, base + 8'(i), (i == len - 1));
        @(negedge clk);
        acc = (src == 0) ? s0_ready : s1_ready;
        @(posedge clk); #1;
        if (acc) i++;
      end
    end
    set_src(src, 1'b0, 8'h00, 1'b0);
    sent = i;
  endtask

  task automatic add_frame(input int len, input int gap, input bit over, input logic [7:0] base);
    int n;
    for (int k = 0; k < 7; k++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    n = len;
    if (gap >= 0) n = gap;
    if (over) n = MAX_B + 1;
    for (int k = 0; k < n; k++)
      exp_q.push_back({over && (k == n - 1), base + 8'(k)});
    if (gap >= 0) exp_q.push_back({1'b1, 8'h00});
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({nm, " idle"}, int'(busy), 0);
  endtask

  task automatic check_content(input string nm, input int nb);
    int bad_at;
    n_cmp++;
    bad_at = -1;
    if (bytes_q.size() - nb != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s content: got %0d bytes expected %0d", nm, bytes_q.size() - nb, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++)
        if (bad_at < 0 && bytes_q[nb + k] !== exp_q[k]) bad_at = k;
      if (bad_at >= 0) begin
        n_bad++;
        $display("FAIL %s content at %0d: got %h expected %h", nm, bad_at,
                 bytes_q[nb + bad_at], exp_q[bad_at]);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int nb, nf, ng, sent0, sent1, tail, ers;
    nb = bytes_q.size(); nf = flen_q.size(); ng = gap_q.size();
    sent0 = 0; sent1 = 0;
    exp_q.delete();
    if (v.mask == 3) begin
      if (v.first == 0) begin add_frame(v.len0, v.gap0, 0, 8'h00); add_frame(v.len1, -1, v.over1, 8'h80); end
      else              begin add_frame(v.len1, -1, v.over1, 8'h80); add_frame(v.len0, v.gap0, 0, 8'h00); end
    end else if (v.mask == 1) add_frame(v.len0, v.gap0, 0, 8'h00);
    else                      add_frame(v.len1, -1, v.over1, 8'h80);

    fork
      begin if ((v.mask & 1) != 0) drive(0, v.len0, v.gap0, 8'h00, sent0); end
      begin if ((v.mask & 2) != 0) drive(1, v.len1, -1, 8'h80, sent1); end
    join
    if ((v.mask & 1) != 0) check({nm, " s0 accepted"}, sent0, v.len0);
    if ((v.mask & 2) != 0) check({nm, " s1 accepted"}, sent1, v.len1);

    if (v.mask != 3) begin
      tail = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (busy) tail++;
        else break;
      end
      check({nm, " ifg busy tail"}, tail, IFG);
    end
    wait_idle(nm);

    check({nm, " frames"}, flen_q.size() - nf, v.exp_frames);
    check({nm, " first grant"}, int'(fgrant_q[nf]), int'(v.exp_grant));
    if (v.exp_frames == 2) begin
      check({nm, " second grant"}, int'(fgrant_q[nf + 1]),
            (v.exp_grant == 2'b01) ? 2 : 1);
      check({nm, " gap"}, gap_q[ng + 1], IFG);
    end
    check({nm, " txen cycles"}, bytes_q.size() - nb, v.exp_txen);
    ers = 0;
    for (int k = nb; k < bytes_q.size(); k++) ers += int'(bytes_q[k][8]);
    check({nm, " txer cycles"}, ers, v.exp_txer);
    check_content(nm, nb);
  endtask

  vec_t vecs[7];

  initial begin
    int nb, nf, ng, sent, acc_n;
    bit acc;
    vec_t rv;

    vecs[0] = '{1, 0,   60,    0, -1, 1'b0, 1, 2'b01,   68, 0};  // single s0 frame 0x00..0x3B
    vecs[1] = '{2, 1,    0,   64, -1, 1'b0, 1, 2'b10,   72, 0};  // single s1 frame
    vecs[2] = '{3, 0,   60,   64, -1, 1'b0, 2, 2'b01,  140, 0};  // tie, s0 preferred
    vecs[3] = '{3, 0,   60,   64, -1, 1'b0, 2, 2'b01,  140, 0};  // tie again, s0 first again
    vecs[4] = '{1, 0,   64,    0, 20, 1'b0, 1, 2'b01,   29, 1};  // underrun after 20 bytes
    vecs[5] = '{3, 1,   60,   64, -1, 1'b0, 2, 2'b10,  140, 0};  // tie with s1 preferred
    vecs[6] = '{2, 1,    0, 1600, -1, 1'b1, 1, 2'b10, 1527, 1};  // oversize stream on s1

    reset_n = 1'b0;
    set_src(0, 1'b1, 8'hA5, 1'b0);
    set_src(1, 1'b1, 8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    check("reset txd",   int'(gmii_txd), 0);
    check("reset txen",  int'(gmii_txen), 0);
    check("reset txer",  int'(gmii_txer), 0);
    check("reset grant", int'(grant), 0);
    check("reset busy",  int'(busy), 0);
    check("reset s0_ready", int'(s0_ready), 0);
    check("reset s1_ready", int'(s1_ready), 0);
    set_src(0, 1'b0, 8'h00, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-frame, between clock edges, while byte 30 is on the wire.
    acc_n = 0;
    for (int k = 0; k < 200 && acc_n < 30; k++) begin
      set_src(0, 1'b1, 8'(acc_n), 1'b0);
      @(negedge clk);
      acc = s0_ready;
      @(posedge clk); #1;
      if (acc) acc_n++;
    end
    check("midrst bytes before reset", acc_n, 30);
    check("midrst txen before reset", int'(gmii_txen), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst txen",  int'(gmii_txen), 0);
    check("midrst txer",  int'(gmii_txer), 0);
    check("midrst txd",   int'(gmii_txd), 0);
    check("midrst grant", int'(grant), 0);
    check("midrst busy",  int'(busy), 0);
    check("midrst s0_ready", int'(s0_ready), 0);
    set_src(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rv = vecs[0];
    run_vec(rv, "post_reset");

    // Back-to-back frames from s0 only.
    nb = bytes_q.size(); nf = flen_q.size(); ng = gap_q.size();
    drive(0, 64, -1, 8'h00, sent);
    check("b2b first accepted", sent, 64);
    drive(0, 64, -1, 8'h40, sent);
    check("b2b second accepted", sent, 64);
    wait_idle("b2b");
    check("b2b frames", flen_q.size() - nf, 2);
    check("b2b len0", flen_q[nf], 72);
    check("b2b len1", flen_q[nf + 1], 72);
    check("b2b gap", gap_q[ng + 1], IFG);
    check("b2b grant1", int'(fgrant_q[nf + 1]), 1);
    exp_q.delete();
    add_frame(64, -1, 0, 8'h00);
    add_frame(64, -1, 0, 8'h40);
    check_content("b2b", nb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
